branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Parametrised direct-mapped BTB with saturating direction counters. Sits beside the fetch PC register.
//  Fetch gets a same-cycle next-PC prediction. Execute resolves and trains the tables, and raises a
//  redirect on mispredict. This replaces flush-on-every-taken-branch with flush-on-mispredict only.
// PARAMETERS
//  XLEN         32            address/data width
//  BTB_ENTRIES  16            table depth; power of 2, >=2; IDX_W = log2(BTB_ENTRIES)
//  CTR_BITS     2             direction counter width, >=1
// PORTS
//  clock        in   1     rising-edge clock
//  reset        in   1     asynchronous, active-high reset
//  f_pc         in   XLEN  current fetch PC (word aligned)
//  f_next_pc    out  XLEN  predicted next fetch PC
//  f_pred_taken out  1     prediction for f_pc (pipeline carries it to execute)
//  e_valid      in   1     execute-stage slot holds a real (non-bubble) instruction
//  e_pc         in   XLEN  PC of the execute-stage instruction
//  e_is_branch  in   1     conditional branch (opcode 1100011)
//  e_is_jump    in   1     jal/jalr
//  e_taken      in   1     resolved direction (1 for jumps)
//  e_target     in   XLEN  resolved target (ALU result)
//  e_pred_taken in   1     f_pred_taken carried down with this instruction
//  e_pred_tgt   in   XLEN  f_next_pc carried down with this instruction
//  invalidate   in   1     clear all BTB entries (fence.i / context switch)
//  e_mispredict out  1     execute redirect required; flush D and X
//  e_redirect   out  XLEN  correct next PC: e_taken ? e_target : e_pc+4
// BEHAVIOUR
//  - Entry fields: valid, tag = pc[XLEN-1:IDX_W+2], target[XLEN], ctr[CTR_BITS], jmp.
//    Index = pc[IDX_W+1:2].
//  - Lookup (combinational, 0 latency, registered table):
//    hit = valid && tag match; f_pred_taken = hit && (jmp || ctr[MSB]).
//    f_next_pc = f_pred_taken ? target : f_pc+4. Additions wrap modulo 2^XLEN.
//  - Resolve (combinational): actual = e_is_branch|e_is_jump ? e_taken : 0.
//    e_mispredict = e_valid && (actual != e_pred_taken || (actual && e_target != e_pred_tgt)).
//    A non-control instruction predicted taken (alias) mispredicts and redirects to e_pc+4.
//  - Train (posedge, when e_valid && (e_is_branch|e_is_jump)):
//    hit: ctr saturating +1 if taken, -1 if not (no wrap at all-ones/zero). If taken, target <= e_target.
//      jmp <= e_is_jump.
//    miss & taken: allocate/overwrite. valid=1, tag, target=e_target, jmp=e_is_jump,
//      ctr = 1<<(CTR_BITS-1) (weakly taken).
//    miss & not taken: no allocation.
//  - Alias clean-up: if e_valid and a non-control instruction hits its entry, that entry's valid <= 0.
//  - Only one write port. A lookup and a train on the same index in one cycle: lookup sees
//    pre-update contents (read-before-write).
//  - invalidate (sync): all valid <= 0 next edge. It wins over a same-cycle train.
//  - reset (async, any time): all valid=0, ctr=(1<<(CTR_BITS-1))-1 (weakly not-taken),
//    targets/tags=0, stats=0.
//    Consequence: f_pred_taken=0 and f_next_pc=f_pc+4 during/after reset.
//    e_mispredict depends only on inputs.
//  - Mid-operation reset discards all training. No state survives.
// CONFIGURATION
//  BP_STATS_EN defined: adds outputs stat_resolved[31:0] and stat_mispred[31:0].
//    stat_resolved counts trained control instructions; stat_mispred counts cycles with e_mispredict=1.
//    Both wrap at 2^32 and are cleared by reset.
//  BP_STATS_EN undefined: ports and counters absent. Core behaviour is identical.
// TESTING
//  1 reset, f_pc=0x01000000 -> f_pred_taken=0, f_next_pc=0x01000004; e_mispredict=0 while e_valid=0.
//  2 beq @0x01000010 taken to 0x01000040, e_pred_taken=0 -> e_mispredict=1, e_redirect=0x01000040.
//    Next cycle f_pc=0x01000010 -> f_next_pc=0x01000040, f_pred_taken=1.
//  3 same branch not taken twice (CTR_BITS=2) -> ctr 10->01->00; the second resolve mispredicts only
//    if predicted taken. Third lookup predicts 0x01000014.
//  4 jal @0x01000020 to 0x01000100 allocated, then ctr trained down -> still predicted taken (jmp=1).
//  5 alias: add @0x01000050 (index as 0x01000010, BTB_ENTRIES=16) with matching forged entry predicted
//    taken -> e_mispredict=1, e_redirect=0x01000054, entry invalidated.
//  6 invalidate and train asserted together -> all entries invalid next cycle.
//    Assert reset mid-sequence -> every prediction returns pc+4 immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters: same-cycle fetch prediction, execute-stage
// resolve/train and mispredict redirect. Define BP_STATS_EN to add resolve/mispredict counters.
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] f_pc,
  output logic [XLEN-1:0] f_next_pc,
  output logic            f_pred_taken,
  input  logic            e_valid,
  input  logic [XLEN-1:0] e_pc,
  input  logic            e_is_branch,
  input  logic            e_is_jump,
  input  logic            e_taken,
  input  logic [XLEN-1:0] e_target,
  input  logic            e_pred_taken,
  input  logic [XLEN-1:0] e_pred_tgt,
  input  logic            invalidate,
  output logic            e_mispredict,
  output logic [XLEN-1:0] e_redirect
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_resolved,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [XLEN-1:0]     target;
    logic [CTR_BITS-1:0] ctr;
    logic                jmp;
  } entry_t;

  localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT, jmp: 1'b0};

  entry_t           tbl_q [BTB_ENTRIES];
  logic [IDX_W-1:0] f_idx, e_idx;
  entry_t           f_ent, e_ent;
  logic             f_hit, e_hit, e_ctrl, e_actual;
  logic             wr_en;
  entry_t           wr_d;

  // Word-offset bits of the PCs carry no information here.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{f_pc[1:0], e_pc[1:0]};

  // Fetch-side lookup
  assign f_idx        = f_pc[IDX_W+1:2];
  assign f_ent        = tbl_q[f_idx];
  assign f_hit        = f_ent.valid && (f_ent.tag == f_pc[XLEN-1:IDX_W+2]);
  assign f_pred_taken = f_hit && (f_ent.jmp || f_ent.ctr[CTR_BITS-1]);
  assign f_next_pc    = f_pred_taken ? f_ent.target : f_pc + XLEN'(4);

  // Execute-side resolve
  assign e_ctrl       = e_is_branch | e_is_jump;
  assign e_actual     = e_ctrl & e_taken;
  assign e_mispredict = e_valid && ((e_actual != e_pred_taken) ||
                                    (e_actual && (e_target != e_pred_tgt)));
  assign e_redirect   = e_actual ? e_target : e_pc + XLEN'(4);

  assign e_idx = e_pc[IDX_W+1:2];
  assign e_ent = tbl_q[e_idx];
  assign e_hit = e_ent.valid && (e_ent.tag == e_pc[XLEN-1:IDX_W+2]);

  always_comb begin
    wr_en = 1'b0;
    wr_d  = e_ent;
    if (e_valid && e_ctrl) begin
      if (e_hit) begin
        wr_en = 1'b1;
        if (e_taken && (e_ent.ctr != '1))
          wr_d.ctr = e_ent.ctr + CTR_BITS'(1);
        else if (!e_taken && (e_ent.ctr != '0))
          wr_d.ctr = e_ent.ctr - CTR_BITS'(1);
        if (e_taken)
          wr_d.target = e_target;
        wr_d.jmp = e_is_jump;
      end else if (e_taken) begin
        wr_en = 1'b1;
        wr_d  = '{valid: 1'b1, tag: e_pc[XLEN-1:IDX_W+2], target: e_target,
                  ctr: CTR_WT, jmp: e_is_jump};
      end
    end else if (e_valid && e_hit) begin
      // A non-control instruction hitting the table is an alias: drop the entry.
      wr_en      = 1'b1;
      wr_d.valid = 1'b0;
    end
  end

  // NOTE: the table is flops, not RAM, so it is reset in full; non-blocking writes make a
  // same-cycle lookup on the trained index see the pre-update entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BTB_ENTRIES; i++) tbl_q[i] <= RST_ENTRY;
    end else if (invalidate) begin
      for (int i = 0; i < BTB_ENTRIES; i++) tbl_q[i].valid <= 1'b0;
    end else if (wr_en) begin
      tbl_q[e_idx] <= wr_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_resolved_q, stat_mispred_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      if (e_valid && e_ctrl) stat_resolved_q <= stat_resolved_q + 32'd1;
      if (e_mispredict)      stat_mispred_q  <= stat_mispred_q + 32'd1;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule
